// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Galois LFSR with seed load, all-zero lockup recovery
// and an LSB-first word packer using valid/ready backpressure.
// Optional feature macro: LFSR_PERIOD_CNT_EN adds a saturating step counter
// and the PERIOD_LEN output, which reports the measured period.
module lfsr_gen #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     POLY      = 8'h95,
  parameter logic [WIDTH-1:0]     SEED      = 8'h06,
  parameter int unsigned          WORD_BITS = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LFSR_EN,
  input  logic                  LOAD,
  input  logic [WIDTH-1:0]      LOAD_VAL,
  input  logic                  OUT_READY,
  output logic [WIDTH-1:0]      LFSR_STATE,
  output logic                  LFSR_BIT,
  output logic                  LFSR_PERIOD,
  output logic                  LOCKUP,
`ifdef LFSR_PERIOD_CNT_EN
  output logic [WIDTH-1:0]      PERIOD_LEN,
`endif
  output logic [WORD_BITS-1:0]  OUT_WORD,
  output logic                  OUT_VALID
);

  localparam int unsigned CW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  logic [WIDTH-1:0]     state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [WORD_BITS-1:0] acc_q, acc_shift;
  logic [WORD_BITS-1:0] word_q;
  logic                 valid_q, lockup_q;
  logic                 zero, last, stall, step, recover;

  // Galois step: shift right, fold the dropped bit back through the tap mask
  always_comb begin
    state_d = (state_q >> 1) ^ (POLY & {WIDTH{state_q[0]}});
  end

  // Oldest bit ends up in the LSB once the word is complete
  if (WORD_BITS > 1) begin : g_shift
    assign acc_shift = {state_q[0], acc_q[WORD_BITS-1:1]};
  end else begin : g_shift1
    assign acc_shift = state_q[0];
  end

  // acc_q[0] is always shifted out before a word completes
  logic unused_acc0;
  assign unused_acc0 = acc_q[0];

  assign zero    = (state_q == '0);
  assign last    = (cnt_q == CW'(WORD_BITS - 1));
  assign stall   = valid_q & ~OUT_READY & last;
  assign step    = LFSR_EN & ~LOAD & ~stall & ~zero;
  assign recover = LFSR_EN & ~LOAD & zero;

  // State register, packer count and accumulator
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= SEED;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else if (LOAD) begin
      state_q <= LOAD_VAL;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else if (recover) begin
      state_q <= SEED;
    end else if (step) begin
      state_q <= state_d;
      acc_q   <= acc_shift;
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
    end
  end

  // Output word/valid: transfer clears valid unless a new word lands the same cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (step && last) begin
      word_q  <= acc_shift;
      valid_q <= 1'b1;
    end else if (valid_q && OUT_READY) begin
      valid_q <= 1'b0;
    end
  end

  // One-cycle pulse flagging recovery from the all-zero state
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) lockup_q <= 1'b0;
    else        lockup_q <= recover;
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] pcnt_q, plen_q, pcnt_inc;

  assign pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + WIDTH'(1);

  // Steps since the last all-ones state; latched into PERIOD_LEN when it recurs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pcnt_q <= '0;
      plen_q <= '0;
    end else if (LOAD || recover) begin
      pcnt_q <= '0;
    end else if (step) begin
      if (LFSR_PERIOD) begin
        plen_q <= pcnt_inc;
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_inc;
      end
    end
  end

  assign PERIOD_LEN = plen_q;
`endif

  assign LFSR_STATE  = state_q;
  assign LFSR_BIT    = state_q[0];
  assign LFSR_PERIOD = (state_q == '1);
  assign LOCKUP      = lockup_q;
  assign OUT_WORD    = word_q;
  assign OUT_VALID   = valid_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen (WIDTH=8, POLY=95, SEED=06, WORD_BITS=8).
// Expected values are hand-computed state/word sequences.
module tb_lfsr_gen;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       LFSR_EN = 1'b0, LOAD = 1'b0, OUT_READY = 1'b0;
  logic [7:0] LOAD_VAL = 8'h00;
  logic [7:0] LFSR_STATE, OUT_WORD;
  logic       LFSR_BIT, LFSR_PERIOD, LOCKUP, OUT_VALID;
`ifdef LFSR_PERIOD_CNT_EN
  logic [7:0] PERIOD_LEN;
`endif

  int nvec = 0;
  int nerr = 0;

  lfsr_gen #(.WIDTH(8), .POLY(8'h95), .SEED(8'h06), .WORD_BITS(8)) dut (
    .CLK(CLK), .RESET(RESET), .LFSR_EN(LFSR_EN), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .OUT_READY(OUT_READY),
    .LFSR_STATE(LFSR_STATE), .LFSR_BIT(LFSR_BIT), .LFSR_PERIOD(LFSR_PERIOD),
    .LOCKUP(LOCKUP),
`ifdef LFSR_PERIOD_CNT_EN
    .PERIOD_LEN(PERIOD_LEN),
`endif
    .OUT_WORD(OUT_WORD), .OUT_VALID(OUT_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] s1 [8] = '{8'h03, 8'h94, 8'h4A, 8'h25, 8'h87, 8'hD6, 8'h6B, 8'hA0};
  logic [7:0] s3 [7] = '{8'h50, 8'h28, 8'h14, 8'h0A, 8'h05, 8'h97, 8'hDE};

  initial begin
    int hit;
    // reset state
    tick(); tick();
    chk("rst_state", LFSR_STATE, 8'h06);
    chk("rst_valid", OUT_VALID, 1'b0);
    chk("rst_word", OUT_WORD, 8'h00);
    chk("rst_lockup", LOCKUP, 1'b0);
    chk("rst_bit", LFSR_BIT, 1'b0);
    RESET = 1'b1; LFSR_EN = 1'b1; OUT_READY = 1'b1;

    // first 4 steps, then a 5-cycle stall with LFSR_EN low
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("run_state%0d", i), LFSR_STATE, s1[i]);
      chk("run_valid", OUT_VALID, 1'b0);
    end
    LFSR_EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_state", LFSR_STATE, 8'h25);
      chk("hold_valid", OUT_VALID, 1'b0);
    end
    LFSR_EN = 1'b1;
    for (int i = 4; i < 8; i++) begin
      tick();
      chk($sformatf("run_state%0d", i), LFSR_STATE, s1[i]);
    end
    chk("w1_valid", OUT_VALID, 1'b1);
    chk("w1_word", OUT_WORD, 8'hB2);

    // backpressure: word held, stepping stalls on the completing bit
    OUT_READY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("bp_state%0d", i), LFSR_STATE, s3[i]);
    end
    chk("bp_valid", OUT_VALID, 1'b1);
    chk("bp_word", OUT_WORD, 8'hB2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_state", LFSR_STATE, 8'hDE);
      chk("stall_word", OUT_WORD, 8'hB2);
      chk("stall_valid", OUT_VALID, 1'b1);
    end
    OUT_READY = 1'b1;
    tick();
    chk("w2_state", LFSR_STATE, 8'h6F);
    chk("w2_word", OUT_WORD, 8'h60);
    chk("w2_valid", OUT_VALID, 1'b1);
    tick();
    chk("w2_drain_state", LFSR_STATE, 8'hA2);
    chk("w2_drain_valid", OUT_VALID, 1'b0);
    chk("period_low", LFSR_PERIOD, 1'b0);

    // zero load and lockup recovery
    LOAD = 1'b1; LOAD_VAL = 8'h00;
    tick();
    chk("ld0_state", LFSR_STATE, 8'h00);
    chk("ld0_lockup", LOCKUP, 1'b0);
    LOAD = 1'b0; LFSR_EN = 1'b0;
    tick();
    chk("zero_hold", LFSR_STATE, 8'h00);
    chk("zero_hold_lockup", LOCKUP, 1'b0);
    LFSR_EN = 1'b1;
    tick();
    chk("rec_state", LFSR_STATE, 8'h06);
    chk("rec_lockup", LOCKUP, 1'b1);
    chk("rec_valid", OUT_VALID, 1'b0);
    tick();
    chk("rec_step", LFSR_STATE, 8'h03);
    chk("rec_lockup_end", LOCKUP, 1'b0);
    repeat (7) tick();
    chk("rec_w_state", LFSR_STATE, 8'hA0);
    chk("rec_w_valid", OUT_VALID, 1'b1);
    chk("rec_w_word", OUT_WORD, 8'hB2);

    // asynchronous reset mid-cycle with a word pending
    #2 RESET = 1'b0;
    #1;
    chk("arst_state", LFSR_STATE, 8'h06);
    chk("arst_valid", OUT_VALID, 1'b0);
    chk("arst_word", OUT_WORD, 8'h00);
    chk("arst_lockup", LOCKUP, 1'b0);
    tick();
    RESET = 1'b1;

    // full period from all ones
    LOAD = 1'b1; LOAD_VAL = 8'hFF;
    tick();
    chk("ff_state", LFSR_STATE, 8'hFF);
    chk("ff_period", LFSR_PERIOD, 1'b1);
    LOAD = 1'b0;
    hit = 0;
    for (int n = 1; n <= 300; n++) begin
      tick();
`ifdef LFSR_PERIOD_CNT_EN
      if (n == 1) chk("plen_first", PERIOD_LEN, 8'd1);
`endif
      if (LFSR_PERIOD) begin
        hit = n;
        break;
      end
    end
    chk("period_steps", hit, 255);
`ifdef LFSR_PERIOD_CNT_EN
    tick();
    chk("plen_255", PERIOD_LEN, 8'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
